// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: PC handshake, instruction memory req/ack, and decode handshake.
// if_fault exists only when FETCH_ALIGN_CHECK_EN is defined.
interface instr_fetch_unit_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        if_fault;
`endif

  modport master (
    input  pc_in, pc_valid, flush, imem_ack, imem_rdata, if_ready,
    output pc_ready, imem_req, imem_addr, if_valid, if_instr, if_pc
`ifdef FETCH_ALIGN_CHECK_EN
    , output if_fault
`endif
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_ack, imem_rdata, if_ready,
    input  pc_ready, imem_req, imem_addr, if_valid, if_instr, if_pc
`ifdef FETCH_ALIGN_CHECK_EN
    , input if_fault
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, results buffered in a DEPTH-entry FIFO.
// FETCH_ALIGN_CHECK_EN: misaligned PCs skip memory and enqueue a faulting NOP instead.
module instr_fetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic [PW+1:0] occ;
  logic [31:0]   addr_q;
  logic [31:0]   push_instr;
  logic          empty, pop, push, push_ack, accept, aligned, space, outstanding;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          fault_mem [DEPTH];
  logic          fault_pending, push_fault;
`endif

  assign empty    = (count == '0);
  assign pop      = !empty && bus.if_ready;
  assign push_ack = (state == REQ) && bus.imem_ack && !bus.flush;

`ifdef FETCH_ALIGN_CHECK_EN
  assign aligned     = (bus.pc_in[1:0] == 2'b00);
  assign push_fault  = fault_pending && !bus.flush;
  assign push        = push_ack || push_fault;
  assign push_instr  = push_fault ? NOP_INSTR : bus.imem_rdata;
  assign outstanding = (state != IDLE) || fault_pending;
`else
  assign aligned     = 1'b1;
  assign push        = push_ack;
  assign push_instr  = bus.imem_rdata;
  assign outstanding = (state != IDLE);
`endif

  // A pop this cycle frees a slot in time for the fetch being accepted now.
  assign occ   = (PW+2)'(count) + (PW+2)'(outstanding) - (PW+2)'(pop);
  assign space = occ < (PW+2)'(DEPTH);

  assign bus.pc_ready = rst_n && !bus.flush && space &&
                        ((state == IDLE) || ((state == REQ) && bus.imem_ack));
  assign accept       = bus.pc_valid && bus.pc_ready;

  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = !empty;
  assign bus.if_instr  = empty ? NOP_INSTR : instr_mem[rptr];
  assign bus.if_pc     = empty ? 32'h0 : pc_mem[rptr];
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.if_fault  = !empty && fault_mem[rptr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Memory cannot abort a read, so a flush mid-request parks in DRAIN until the ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && aligned) state_next = REQ;
      REQ: begin
        if (bus.flush)         state_next = bus.imem_ack ? IDLE : DRAIN;
        else if (bus.imem_ack) state_next = (accept && aligned) ? REQ : IDLE;
      end
      DRAIN:   if (bus.imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_pending <= 1'b0;
`endif
    end else begin
`ifdef FETCH_ALIGN_CHECK_EN
      fault_pending <= accept && !aligned;
      if (accept) addr_q <= bus.pc_in;
`else
      if (accept) addr_q <= bus.pc_in & 32'hFFFF_FFFC;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]    <= addr_q;
      instr_mem[wptr] <= push_instr;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_mem[wptr] <= push_fault;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=2).
// Alignment checks follow FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        auto_ack = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  // Zero-wait memory in auto mode, hand-driven ack/data otherwise.
  always_comb begin
    if (auto_ack) begin
      bus.imem_ack   = bus.imem_req;
      bus.imem_rdata = instr_of(bus.imem_addr);
    end else begin
      bus.imem_ack   = man_ack;
      bus.imem_rdata = man_rdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.pc_in = 32'h0; bus.pc_valid = 1'b1; bus.flush = 1'b0; bus.if_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_compared++; if (bus.imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_imem_req: got %b want 0", bus.imem_req); end
    n_compared++; if (bus.imem_addr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_imem_addr: got %h want 0", bus.imem_addr); end
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_if_valid: got %b want 0", bus.if_valid); end
    n_compared++; if (bus.if_instr !== NOP) begin n_mismatched++; $display("[TB] FAIL rst_if_instr: got %h want %h", bus.if_instr, NOP); end
    n_compared++; if (bus.if_pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_if_pc: got %h want 0", bus.if_pc); end
    n_compared++; if (bus.pc_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_pc_ready: got %b want 0", bus.pc_ready); end
    bus.pc_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask

  task automatic test_zero_wait;
    auto_ack = 1'b1; bus.if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.pc_in = 32'(4 * k); bus.pc_valid = 1'b1;
      #1;
      n_compared++; if (bus.pc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zw_pc_ready k=%0d: got %b want 1", k, bus.pc_ready); end
      if (k >= 2) begin
        n_compared++; if (bus.if_pc !== 32'(4 * (k - 2))) begin n_mismatched++; $display("[TB] FAIL zw_if_pc k=%0d: got %h want %h", k, bus.if_pc, 32'(4 * (k - 2))); end
        n_compared++; if (bus.if_instr !== instr_of(32'(4 * (k - 2)))) begin n_mismatched++; $display("[TB] FAIL zw_if_instr k=%0d: got %h want %h", k, bus.if_instr, instr_of(32'(4 * (k - 2)))); end
      end
      tick;
    end
    bus.pc_valid = 1'b0;
    #1;
    n_compared++; if (bus.if_pc !== 32'h8) begin n_mismatched++; $display("[TB] FAIL zw_if_pc_8: got %h want 8", bus.if_pc); end
    tick;
    n_compared++; if (bus.if_pc !== 32'hC) begin n_mismatched++; $display("[TB] FAIL zw_if_pc_12: got %h want c", bus.if_pc); end
    tick;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zw_empty: got %b want 0", bus.if_valid); end
    bus.if_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    auto_ack = 1'b1; bus.if_ready = 1'b0;
    bus.pc_in = 32'h100; bus.pc_valid = 1'b1;
    tick;
    bus.pc_in = 32'h104;
    tick;
    bus.pc_in = 32'h108;
    #1;
    n_compared++; if (bus.pc_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_credit_stall: got %b want 0", bus.pc_ready); end
    tick;
    #1;
    n_compared++; if (bus.pc_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_full_pc_ready: got %b want 0", bus.pc_ready); end
    n_compared++; if (bus.imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_full_imem_req: got %b want 0", bus.imem_req); end
    n_compared++; if (bus.if_pc !== 32'h100) begin n_mismatched++; $display("[TB] FAIL bp_head: got %h want 100", bus.if_pc); end
    bus.if_ready = 1'b1;
    #1;
    n_compared++; if (bus.pc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_full_pop_ready: got %b want 1", bus.pc_ready); end
    tick;
    bus.pc_valid = 1'b0;
    #1;
    n_compared++; if (bus.if_pc !== 32'h104) begin n_mismatched++; $display("[TB] FAIL bp_second: got %h want 104", bus.if_pc); end
    n_compared++; if (bus.imem_addr !== 32'h108) begin n_mismatched++; $display("[TB] FAIL bp_resume_addr: got %h want 108", bus.imem_addr); end
    tick;
    n_compared++; if (bus.if_pc !== 32'h108) begin n_mismatched++; $display("[TB] FAIL bp_third: got %h want 108", bus.if_pc); end
    tick;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_empty: got %b want 0", bus.if_valid); end
    bus.if_ready = 1'b0;
  endtask

  task automatic test_flush_drain;
    auto_ack = 1'b0; man_ack = 1'b0; bus.if_ready = 1'b1;
    bus.pc_in = 32'h20; bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0; bus.flush = 1'b1;
    #1;
    n_compared++; if (bus.pc_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fd_flush_ready: got %b want 0", bus.pc_ready); end
    tick;
    bus.flush = 1'b0; bus.pc_in = 32'h40; bus.pc_valid = 1'b1;
    #1;
    n_compared++; if (bus.imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fd_req_held: got %b want 1", bus.imem_req); end
    n_compared++; if (bus.imem_addr !== 32'h20) begin n_mismatched++; $display("[TB] FAIL fd_addr_held: got %h want 20", bus.imem_addr); end
    n_compared++; if (bus.pc_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fd_drain_ready1: got %b want 0", bus.pc_ready); end
    tick;
    tick;
    man_ack = 1'b1; man_rdata = 32'hDEADBEEF;
    #1;
    n_compared++; if (bus.pc_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fd_drain_ack_ready: got %b want 0", bus.pc_ready); end
    tick;
    man_ack = 1'b0;
    #1;
    n_compared++; if (bus.imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fd_idle_req: got %b want 0", bus.imem_req); end
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fd_dropped: got %b want 0", bus.if_valid); end
    n_compared++; if (bus.pc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fd_idle_ready: got %b want 1", bus.pc_ready); end
    tick;
    bus.pc_valid = 1'b0;
    #1;
    n_compared++; if (bus.imem_addr !== 32'h40) begin n_mismatched++; $display("[TB] FAIL fd_new_addr: got %h want 40", bus.imem_addr); end
    man_ack = 1'b1; man_rdata = instr_of(32'h40);
    tick;
    man_ack = 1'b0;
    #1;
    n_compared++; if (bus.if_pc !== 32'h40) begin n_mismatched++; $display("[TB] FAIL fd_new_pc: got %h want 40", bus.if_pc); end
    n_compared++; if (bus.if_instr !== instr_of(32'h40)) begin n_mismatched++; $display("[TB] FAIL fd_new_instr: got %h want %h", bus.if_instr, instr_of(32'h40)); end
    tick;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fd_end_empty: got %b want 0", bus.if_valid); end
    bus.if_ready = 1'b0; auto_ack = 1'b1;
  endtask

  task automatic test_flush_full;
    auto_ack = 1'b1; bus.if_ready = 1'b0;
    bus.pc_in = 32'h80; bus.pc_valid = 1'b1;
    tick;
    bus.pc_in = 32'h84;
    tick;
    bus.pc_valid = 1'b0;
    tick;
    n_compared++; if (bus.if_pc !== 32'h80) begin n_mismatched++; $display("[TB] FAIL ff_full_head: got %h want 80", bus.if_pc); end
    bus.flush = 1'b1; bus.if_ready = 1'b1;
    tick;
    bus.flush = 1'b0; bus.if_ready = 1'b0;
    #1;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ff_full_flush_valid: got %b want 0", bus.if_valid); end
    n_compared++; if (bus.if_instr !== NOP) begin n_mismatched++; $display("[TB] FAIL ff_full_flush_instr: got %h want %h", bus.if_instr, NOP); end
    bus.pc_in = 32'hA0; bus.pc_valid = 1'b1;
    tick;
    bus.pc_in = 32'hA4;
    tick;
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.if_ready = 1'b1;
    #1;
    n_compared++; if (bus.if_pc !== 32'hA0) begin n_mismatched++; $display("[TB] FAIL ff_ack_head: got %h want a0", bus.if_pc); end
    tick;
    bus.flush = 1'b0; bus.if_ready = 1'b0;
    #1;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ff_ack_flush_valid: got %b want 0", bus.if_valid); end
    n_compared++; if (bus.imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ff_ack_flush_req: got %b want 0", bus.imem_req); end
    tick;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ff_no_stale: got %b want 0", bus.if_valid); end
    bus.pc_in = 32'hB0; bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0;
    tick;
    n_compared++; if (bus.if_pc !== 32'hB0) begin n_mismatched++; $display("[TB] FAIL ff_clean_refetch: got %h want b0", bus.if_pc); end
    bus.if_ready = 1'b1;
    tick;
    bus.if_ready = 1'b0;
  endtask

  task automatic test_align;
`ifdef FETCH_ALIGN_CHECK_EN
    auto_ack = 1'b1; bus.if_ready = 1'b0;
    bus.pc_in = 32'h6; bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0;
    #1;
    n_compared++; if (bus.imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL al_no_req: got %b want 0", bus.imem_req); end
    tick;
    n_compared++; if (bus.if_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL al_valid: got %b want 1", bus.if_valid); end
    n_compared++; if (bus.if_fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL al_fault: got %b want 1", bus.if_fault); end
    n_compared++; if (bus.if_pc !== 32'h6) begin n_mismatched++; $display("[TB] FAIL al_pc: got %h want 6", bus.if_pc); end
    n_compared++; if (bus.if_instr !== NOP) begin n_mismatched++; $display("[TB] FAIL al_instr: got %h want %h", bus.if_instr, NOP); end
    bus.if_ready = 1'b1;
    tick;
    n_compared++; if (bus.if_fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL al_fault_clear: got %b want 0", bus.if_fault); end
    bus.if_ready = 1'b0;
`else
    auto_ack = 1'b0; man_ack = 1'b0; bus.if_ready = 1'b0;
    bus.pc_in = 32'h6; bus.pc_valid = 1'b1;
    tick;
    bus.pc_valid = 1'b0;
    #1;
    n_compared++; if (bus.imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL al_req: got %b want 1", bus.imem_req); end
    n_compared++; if (bus.imem_addr !== 32'h4) begin n_mismatched++; $display("[TB] FAIL al_forced_addr: got %h want 4", bus.imem_addr); end
    man_ack = 1'b1; man_rdata = 32'hCAFE0004;
    tick;
    man_ack = 1'b0;
    #1;
    n_compared++; if (bus.if_pc !== 32'h4) begin n_mismatched++; $display("[TB] FAIL al_pc: got %h want 4", bus.if_pc); end
    n_compared++; if (bus.if_instr !== 32'hCAFE0004) begin n_mismatched++; $display("[TB] FAIL al_instr: got %h want cafe0004", bus.if_instr); end
    bus.if_ready = 1'b1;
    tick;
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL al_empty: got %b want 0", bus.if_valid); end
    bus.if_ready = 1'b0; auto_ack = 1'b1;
`endif
  endtask

  task automatic test_reset_mid_fetch;
    auto_ack = 1'b1; bus.if_ready = 1'b0;
    bus.pc_in = 32'h10; bus.pc_valid = 1'b1;
    tick;
    bus.pc_in = 32'h14;
    tick;
    auto_ack = 1'b0; man_ack = 1'b0; bus.pc_valid = 1'b0;
    #1;
    n_compared++; if (bus.imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_req_before: got %b want 1", bus.imem_req); end
    n_compared++; if (bus.if_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_valid_before: got %b want 1", bus.if_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_compared++; if (bus.imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_req: got %b want 0", bus.imem_req); end
    n_compared++; if (bus.if_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_valid: got %b want 0", bus.if_valid); end
    n_compared++; if (bus.if_instr !== NOP) begin n_mismatched++; $display("[TB] FAIL rm_instr: got %h want %h", bus.if_instr, NOP); end
    n_compared++; if (bus.imem_addr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rm_addr: got %h want 0", bus.imem_addr); end
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_backpressure;
    test_flush_drain;
    test_flush_full;
    test_align;
    test_reset_mid_fetch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
